gray_ptr_rx: RTL and testbench

Receiving end of a gray-coded pointer/count crossing into this clock domain. Each upstream `binary_code` value is converted to gray and driven across a domain boundary. This block samples that gray word and synchronizes it. It decodes it back to binary, reports each ±1 step with direction, and flags any sample where more than one bit changed. Typical use is the read/write pointer receive side of an async FIFO, or a remote position counter.

---
 rtl/gray_pkg.sv | 20 ++
 rtl/sync_chain.sv | 20 ++
 rtl/gray_ptr_rx.sv | 62 ++++++
 tb/tb_gray_ptr_rx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: gray/binary conversion helpers, popcount and receiver FSM state type.
package gray_pkg;
  typedef enum logic {PRIME, TRACK} gray_rx_state_t;
  // Helpers work on a 32-bit zero-extended word; callers truncate to their width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchronizer for a bus, async active-low reset to 0.
module sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s [STAGES];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s <= '{default: '0};
    else begin
      s[0] <= d;
      for (int i = 1; i < STAGES; i++) s[i] <= s[i-1];
    end
  end
  assign q = s[STAGES-1];
endmodule

// File: rtl/gray_ptr_rx.sv
// gray_ptr_rx: synchronizes a gray-coded pointer, decodes it and reports steps and multi-bit errors.
module gray_ptr_rx
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_valid,
  output logic             step_up,
  output logic             err,
  output logic             err_sticky
);
  localparam int CW = $clog2(SYNC_STAGES + 1);
  gray_rx_state_t   state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] g_s, g_q, b_s;
  logic [5:0]       pc;
  logic             step, bad;
  sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .d(gray_in), .q(g_s)
  );
  assign b_s  = WIDTH'(gray2bin(32'(g_s)));
  assign pc   = popcount(32'(g_s ^ g_q));
  assign step = state == TRACK && pc == 6'd1;
  assign bad  = state == TRACK && pc > 6'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PRIME;
      cnt        <= '0;
      g_q        <= '0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      step_valid <= 1'b0;
      step_up    <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      step_valid <= step;
      err        <= bad;
      err_sticky <= bad | (err_sticky & ~clr_err);
      if (state == PRIME) begin
        if (cnt == CW'(SYNC_STAGES)) begin
          g_q       <= g_s;
          bin_out   <= b_s;
          bin_valid <= 1'b1;
          state     <= TRACK;
        end else cnt <= cnt + 1'b1;
      end else if (pc != 6'd0) begin
        // errors also resynchronize so tracking resumes from the new value
        g_q     <= g_s;
        bin_out <= b_s;
        if (step) step_up <= (b_s - bin_out) == WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_gray_ptr_rx.sv
// tb_gray_ptr_rx: directed and randomized checks of gray_ptr_rx at SYNC_STAGES 2 and 3.
module tb_gray_ptr_rx;
  logic       clk = 0, rst_n = 0, clr_err = 0;
  logic [3:0] gray_in = 0;
  logic [3:0] bin2, bin3;
  logic       bv2, sv2, su2, e2, es2, bv3, sv3, su3, e3, es3;
  int errors = 0, checks = 0;
  int hist [0:299];
  always #5 clk = ~clk;
  gray_ptr_rx #(.WIDTH(4), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr_err(clr_err), .bin_out(bin2),
    .bin_valid(bv2), .step_valid(sv2), .step_up(su2), .err(e2), .err_sticky(es2)
  );
  gray_ptr_rx #(.WIDTH(4), .SYNC_STAGES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr_err(clr_err), .bin_out(bin3),
    .bin_valid(bv3), .step_valid(sv3), .step_up(su3), .err(e3), .err_sticky(es3)
  );
  function automatic logic [3:0] b2g(input int b);
    return 4'(b ^ (b >> 1));
  endfunction
  function automatic int g2b(input logic [3:0] g);
    for (int b = 0; b < 16; b++) if (b2g(b) == g) return b;
    return -1;
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic test_reset;
    rst_n = 0; gray_in = 4'b0111; clr_err = 0;
    tick(2);
    checks++;
    if ({bin2, bv2, sv2, su2, e2, es2} !== 9'd0) begin errors++; $display("FAIL reset_vals got=%b want=0", {bin2, bv2, sv2, su2, e2, es2}); end
    rst_n = 1;
    tick(2);
    checks++;
    if (bv2 !== 1'b0) begin errors++; $display("FAIL prime_early bin_valid got=%b want=0", bv2); end
    tick();
    checks++;
    if (bv2 !== 1'b1 || bin2 !== 4'd5) begin errors++; $display("FAIL prime_done valid=%b bin=%0d want 1,5", bv2, bin2); end
    checks++;
    if (sv2 !== 1'b0 || e2 !== 1'b0) begin errors++; $display("FAIL prime_events step=%b err=%b want 0,0", sv2, e2); end
  endtask
  task automatic test_steps;
    gray_in = 4'b0101; tick();
    gray_in = 4'b0100; tick(2);
    checks++;
    if (bin2 !== 4'd6 || sv2 !== 1'b1 || su2 !== 1'b1) begin errors++; $display("FAIL step1 bin=%0d sv=%b up=%b want 6,1,1", bin2, sv2, su2); end
    tick();
    checks++;
    if (bin2 !== 4'd7 || sv2 !== 1'b1 || su2 !== 1'b1) begin errors++; $display("FAIL step2 bin=%0d sv=%b up=%b want 7,1,1", bin2, sv2, su2); end
    tick();
    checks++;
    if (sv2 !== 1'b0) begin errors++; $display("FAIL step_pulse sv=%b want 0", sv2); end
  endtask
  task automatic test_wrap;
    gray_in = 4'b0000; tick(4);
    gray_in = 4'b1000; tick(3);
    checks++;
    if (bin2 !== 4'd15 || sv2 !== 1'b1 || su2 !== 1'b0) begin errors++; $display("FAIL wrap_down bin=%0d sv=%b up=%b want 15,1,0", bin2, sv2, su2); end
    gray_in = 4'b0000; tick(3);
    checks++;
    if (bin2 !== 4'd0 || sv2 !== 1'b1 || su2 !== 1'b1) begin errors++; $display("FAIL wrap_up bin=%0d sv=%b up=%b want 0,1,1", bin2, sv2, su2); end
    tick();
    checks++;
    if (su2 !== 1'b1) begin errors++; $display("FAIL step_up_held up=%b want 1", su2); end
  endtask
  task automatic test_err;
    gray_in = 4'b0011; tick(3);
    checks++;
    if (e2 !== 1'b1 || es2 !== 1'b1 || bin2 !== 4'd2 || sv2 !== 1'b0) begin errors++; $display("FAIL err1 err=%b st=%b bin=%0d sv=%b want 1,1,2,0", e2, es2, bin2, sv2); end
    tick();
    checks++;
    if (e2 !== 1'b0 || es2 !== 1'b1) begin errors++; $display("FAIL err_hold err=%b st=%b want 0,1", e2, es2); end
    gray_in = 4'b0000; tick(2);
    clr_err = 1; tick();
    clr_err = 0;
    checks++;
    if (e2 !== 1'b1 || es2 !== 1'b1) begin errors++; $display("FAIL err_set_wins err=%b st=%b want 1,1", e2, es2); end
    clr_err = 1; tick();
    clr_err = 0;
    checks++;
    if (es2 !== 1'b0 || bin2 !== 4'd0) begin errors++; $display("FAIL clr_err st=%b bin=%0d want 0,0", es2, bin2); end
  endtask
  task automatic test_reset_mid;
    gray_in = b2g(9); tick(3);
    checks++;
    if (bin2 !== 4'd9 || es2 !== 1'b1) begin errors++; $display("FAIL pre_reset bin=%0d st=%b want 9,1", bin2, es2); end
    #2 rst_n = 0; #1;
    checks++;
    if ({bin2, bv2, sv2, su2, e2, es2} !== 9'd0) begin errors++; $display("FAIL async_reset got=%b want 0", {bin2, bv2, sv2, su2, e2, es2}); end
    gray_in = 4'b0110; tick();
    rst_n = 1;
    tick(3);
    checks++;
    if (bv2 !== 1'b1 || bin2 !== 4'(g2b(4'b0110))) begin errors++; $display("FAIL reprime valid=%b bin=%0d want 1,%0d", bv2, bin2, g2b(4'b0110)); end
  endtask
  task automatic test_random_walk;
    int b, t, s2u, s3u;
    b = $urandom_range(0, 15);
    rst_n = 0; gray_in = b2g(b); tick();
    rst_n = 1; tick(6);
    for (int i = 0; i < 5; i++) hist[i] = b;
    s2u = 0; s3u = 0;
    for (t = 0; t < 250; t++) begin
      case ($urandom_range(0, 2))
        0: b = (b + 15) % 16;
        1: b = (b + 1) % 16;
        default: ;
      endcase
      hist[t + 5] = b;
      gray_in = b2g(b);
      tick();
      begin
        int cur2, prv2, cur3, prv3;
        cur2 = hist[t + 3]; prv2 = hist[t + 2];
        cur3 = hist[t + 2]; prv3 = hist[t + 1];
        if (cur2 != prv2) s2u = (cur2 == (prv2 + 1) % 16);
        if (cur3 != prv3) s3u = (cur3 == (prv3 + 1) % 16);
        checks++;
        if (bin2 !== 4'(cur2) || sv2 !== (cur2 != prv2) || su2 !== 1'(s2u) || e2 !== 1'b0) begin
          errors++; $display("FAIL walk_s2 t=%0d bin=%0d sv=%b up=%b err=%b want %0d,%0d,%0d,0", t, bin2, sv2, su2, e2, cur2, cur2 != prv2, s2u);
        end
        checks++;
        if (bin3 !== 4'(cur3) || sv3 !== (cur3 != prv3) || su3 !== 1'(s3u) || e3 !== 1'b0) begin
          errors++; $display("FAIL walk_s3 t=%0d bin=%0d sv=%b up=%b err=%b want %0d,%0d,%0d,0", t, bin3, sv3, su3, e3, cur3, cur3 != prv3, s3u);
        end
      end
    end
    checks++;
    if (es2 !== 1'b0 || es3 !== 1'b0) begin errors++; $display("FAIL walk_sticky s2=%b s3=%b want 0,0", es2, es3); end
  endtask
  initial begin
    test_reset();
    test_steps();
    test_wrap();
    test_err();
    test_reset_mid();
    test_random_walk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
